smoldvi_tmds_encode_rd: RTL and testbench

Multi-lane DVI 1.0 TMDS encoder with the full 8b/10b transition-minimising algorithm and a per-lane running-disparity counter. It encodes 8-bit pixel data at full pixel rate, with no pixel doubling and no LSB truncation. It sits between the timing generator and the 10:1 serialisers in the SmolDVI output path and feeds one serialiser per lane. A two-stage pipeline keeps the per-stage logic within one popcount plus adder.

---
 rtl/smoldvi_tmds_encode_rd_if.sv | 36 +++
 rtl/smoldvi_tmds_encode_rd.sv | 187 ++++++++++++++++++
 tb/tb_smoldvi_tmds_encode_rd.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/smoldvi_tmds_encode_rd_if.sv
// ---------------------------------------------------------------------------
// smoldvi_tmds_encode_rd_if
//
// Pixel-side bundle between the timing generator and the TMDS encoder, plus
// the encoded symbols heading to the 10:1 serialisers.
//
//   d    [8*N_CHAN-1:0]   pixel data, lane k = d[8k+7:8k]
//   c    [2*N_CHAN-1:0]   control bits, lane k = c[2k+1:2k] as {c1,c0}
//   den                   data enable shared by all lanes (1 = pixel data)
//   q    [10*N_CHAN-1:0]  TMDS symbols, lane k = q[10k+9:10k], bit 0 sent first
//
// master : the side producing pixels (timing generator / testbench)
// slave  : the encoder
// ---------------------------------------------------------------------------
interface smoldvi_tmds_encode_rd_if #(
  parameter int N_CHAN = 3
);
  logic [8*N_CHAN-1:0]  d;
  logic [2*N_CHAN-1:0]  c;
  logic                 den;
  logic [10*N_CHAN-1:0] q;

  modport master (
    output d,
    output c,
    output den,
    input  q
  );

  modport slave (
    input  d,
    input  c,
    input  den,
    output q
  );
endinterface

// File: rtl/smoldvi_tmds_encode_rd.sv
// ---------------------------------------------------------------------------
// smoldvi_tmds_encode_rd
//
// Multi-lane DVI TMDS encoder: full 8b/10b transition-minimising encoding
// with an independent running-disparity counter per lane. Two pipeline
// stages, fixed latency of two cycles, one symbol per lane per cycle.
//
//   Stage 1 : popcount of the pixel, XOR/XNOR chain -> q_m[8:0];
//             den and c are delayed alongside q_m.
//   Stage 2 : popcount of q_m[7:0], DC-balance decision against cnt,
//             registered symbol q and updated cnt. Control cycles emit
//             one of four fixed tokens and clear cnt.
//
// Ports
//   clk    in   pixel clock
//   rst_n  in   asynchronous, active-low reset (clears both stages and cnt)
//   bus    slave modport of smoldvi_tmds_encode_rd_if (d, c, den in; q out)
//
// Parameters
//   N_CHAN number of independent lanes (>= 1); must match the interface.
// ---------------------------------------------------------------------------
module smoldvi_tmds_encode_rd #(
  parameter int N_CHAN = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  smoldvi_tmds_encode_rd_if.slave  bus
);

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------

  // Number of set bits in a byte, 0..8.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] acc;
    acc = 4'd0;
    for (int i = 0; i < 8; i++) begin
      acc = acc + {3'b000, v[i]};
    end
    return acc;
  endfunction

  // Transition-minimising stage: chain each bit onto the previous output
  // bit with XOR, or XNOR when the byte is ones-heavy (ties broken on
  // d[0]). Bit 8 records which operator was used (1 = XOR).
  function automatic logic [8:0] transition_min(input logic [7:0] v);
    logic [3:0] ones;
    logic       use_xnor;
    logic [8:0] qm;
    ones     = popcount8(v);
    use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !v[0]);
    qm       = 9'd0;
    qm[0]    = v[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = use_xnor ? ~(qm[i-1] ^ v[i]) : (qm[i-1] ^ v[i]);
    end
    qm[8] = ~use_xnor;
    return qm;
  endfunction

  // Control-period tokens, selected by {c1,c0}.
  function automatic logic [9:0] ctrl_token(input logic [1:0] cc);
    logic [9:0] tok;
    case (cc)
      2'b00:   tok = 10'b1101010100;
      2'b01:   tok = 10'b0010101011;
      2'b10:   tok = 10'b0101010100;
      default: tok = 10'b1010101011;
    endcase
    return tok;
  endfunction

  // Packed symbol bus assembled from the per-lane registers.
  logic [10*N_CHAN-1:0] q_all;

  assign bus.q = q_all;

  // -------------------------------------------------------------------------
  // Per-lane datapath. Lanes share only clk, rst_n and den.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_lane

      // Lane slices of the input bus.
      logic [7:0]        d_lane;
      logic [1:0]        c_lane;

      // Stage-1 state.
      logic [8:0]        qm_reg;
      logic              den_d_reg;
      logic [1:0]        c_d_reg;
      logic [8:0]        qm_next;

      // Stage-2 state and its combinational inputs.
      logic [9:0]        q_reg;
      logic [9:0]        q_next;
      logic signed [4:0] cnt_reg;
      logic signed [4:0] cnt_next;

      // Stage-2 working values. One extra bit of headroom so an illegal
      // excursion is visible to the range check rather than wrapping.
      logic [3:0]        n1q;
      logic signed [5:0] bal;       // n1q - n0q, always even, -8..+8
      logic signed [5:0] cnt_ext;
      logic signed [5:0] cnt_calc;
      logic              qm8;

      assign d_lane = bus.d[8*gi +: 8];
      assign c_lane = bus.c[2*gi +: 2];

      // ---------------- stage 1 ----------------
      assign qm_next = transition_min(d_lane);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          qm_reg    <= 9'd0;
          den_d_reg <= 1'b0;
          c_d_reg   <= 2'b00;
        end else begin
          qm_reg    <= qm_next;
          den_d_reg <= bus.den;
          c_d_reg   <= c_lane;
        end
      end

      // ---------------- stage 2 ----------------
      always_comb begin
        n1q      = popcount8(qm_reg[7:0]);
        // 2*n1q - 8 equals n1q - n0q since n0q = 8 - n1q.
        bal      = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
        cnt_ext  = $signed({cnt_reg[4], cnt_reg});
        qm8      = qm_reg[8];
        q_next   = 10'd0;
        cnt_calc = 6'sd0;

        if (!den_d_reg) begin
          // Control period: fixed token, disparity restarts from zero.
          q_next   = ctrl_token(c_d_reg);
          cnt_calc = 6'sd0;
        end else if ((cnt_reg == 5'sd0) || (bal == 6'sd0)) begin
          // No accumulated bias, or a balanced word: bit 9 simply
          // complements bit 8, and the payload is inverted when XNOR
          // was used so the decoder can tell the two cases apart.
          q_next = {~qm8, qm8, (qm8 ? qm_reg[7:0] : ~qm_reg[7:0])};
          if (qm8) begin
            cnt_calc = cnt_ext + bal;
          end else begin
            cnt_calc = cnt_ext - bal;
          end
        end else if ((!cnt_reg[4] && (bal > 6'sd0)) ||
                     ( cnt_reg[4] && (bal < 6'sd0))) begin
          // Word would push the bias further the same way: invert it.
          q_next   = {1'b1, qm8, ~qm_reg[7:0]};
          cnt_calc = cnt_ext + (qm8 ? 6'sd2 : 6'sd0) - bal;
        end else begin
          // Word already pulls the bias back toward zero: send as is.
          q_next   = {1'b0, qm8, qm_reg[7:0]};
          cnt_calc = cnt_ext - (qm8 ? 6'sd0 : 6'sd2) + bal;
        end

        cnt_next = cnt_calc[4:0];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg   <= 10'd0;
          cnt_reg <= 5'sd0;
        end else begin
          q_reg   <= q_next;
          cnt_reg <= cnt_next;
        end
      end

      assign q_all[10*gi +: 10] = q_reg;

      // The balancing rules keep cnt even and within +/-8; anything else
      // means the decision logic is broken.
      a_cnt_range : assert property (
        @(posedge clk) disable iff (!rst_n)
          (cnt_calc >= -6'sd8) && (cnt_calc <= 6'sd8) && !cnt_calc[0]
      );

    end : g_lane
  endgenerate

endmodule

// File: tb/tb_smoldvi_tmds_encode_rd.sv
// ---------------------------------------------------------------------------
// tb_smoldvi_tmds_encode_rd
//
// Drives a 3-lane encoder with directed sequences (reset, control tokens,
// constant pixels from a control period, multi-lane mix, mid-frame reset,
// den toggling) and a stretch of random traffic. A behavioural TMDS model
// predicts every symbol; a compare process checks all lanes every cycle and
// also decodes data symbols back to the pixel that produced them. Literal,
// hand-derived symbols pin the model at known points.
// ---------------------------------------------------------------------------
module tb_smoldvi_tmds_encode_rd;

  localparam int N = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  smoldvi_tmds_encode_rd_if #(.N_CHAN(N)) bus ();

  smoldvi_tmds_encode_rd #(.N_CHAN(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // One comparison; 'loud' prints a line for directed transactions.
  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want, input bit loud);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, got, want, $time);
    end else if (loud) begin
      $display("check %s: %h ok (t=%0t)", name, got, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [9:0] token_of(input logic [1:0] cc);
    logic [9:0] t;
    case (cc)
      2'b00:   t = 10'h354;
      2'b01:   t = 10'h0AB;
      2'b10:   t = 10'h154;
      default: t = 10'h2AB;
    endcase
    return t;
  endfunction

  task automatic tmds_model(input logic [7:0] v, input int cin,
                            output logic [9:0] sym, output int cout);
    int         ones;
    int         bal;
    logic       xn;
    logic       q8;
    logic [7:0] qm;
    ones  = $countones(v);
    xn    = (ones > 4) || (ones == 4 && v[0] == 1'b0);
    qm    = 8'd0;
    qm[0] = v[0];
    for (int i = 1; i < 8; i++)
      qm[i] = xn ? ~(qm[i-1] ^ v[i]) : (qm[i-1] ^ v[i]);
    q8  = ~xn;
    bal = 2 * $countones(qm) - 8;
    if (cin == 0 || bal == 0) begin
      sym  = {~q8, q8, (q8 ? qm : ~qm)};
      cout = q8 ? cin + bal : cin - bal;
    end else if ((cin > 0 && bal > 0) || (cin < 0 && bal < 0)) begin
      sym  = {1'b1, q8, ~qm};
      cout = cin + (q8 ? 2 : 0) - bal;
    end else begin
      sym  = {1'b0, q8, qm};
      cout = cin - (q8 ? 0 : 2) + bal;
    end
  endtask

  function automatic logic [7:0] tmds_decode(input logic [9:0] s);
    logic [7:0] x;
    logic [7:0] r;
    x    = s[9] ? ~s[7:0] : s[7:0];
    r    = 8'd0;
    r[0] = x[0];
    for (int i = 1; i < 8; i++)
      r[i] = s[8] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
    return r;
  endfunction

  // Inputs seen at the previous edge, and the symbol expected now.
  logic [7:0] s1_d   [N];
  logic [1:0] s1_c   [N];
  logic       s1_den;
  logic [9:0] exp_q  [N];
  logic [7:0] exp_d  [N];
  logic       exp_den;
  int         cnt_m  [N];

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      s1_d[k]  = 8'd0;
      s1_c[k]  = 2'd0;
      exp_q[k] = 10'd0;
      exp_d[k] = 8'd0;
      cnt_m[k] = 0;
    end
    s1_den  = 1'b0;
    exp_den = 1'b0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_clear();
      end else begin
        for (int k = 0; k < N; k++) begin
          if (s1_den) begin
            tmds_model(s1_d[k], cnt_m[k], exp_q[k], cnt_m[k]);
          end else begin
            exp_q[k] = token_of(s1_c[k]);
            cnt_m[k] = 0;
          end
          exp_d[k] = s1_d[k];
        end
        exp_den = s1_den;
        for (int k = 0; k < N; k++) begin
          s1_d[k] = bus.d[8*k +: 8];
          s1_c[k] = bus.c[2*k +: 2];
        end
        s1_den = bus.den;
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        check($sformatf("model q lane%0d", k), 32'(bus.q[10*k +: 10]),
              32'(exp_q[k]), 1'b0);
        if (exp_den)
          check($sformatf("decode lane%0d", k),
                32'(tmds_decode(bus.q[10*k +: 10])), 32'(exp_d[k]), 1'b0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [23:0] dv, input logic [5:0] cv,
                       input logic denv);
    bus.d   = dv;
    bus.c   = cv;
    bus.den = denv;
  endtask

  task automatic lit_all(input string name, input logic [9:0] want);
    for (int k = 0; k < N; k++)
      check($sformatf("%s lane%0d", name, k), 32'(bus.q[10*k +: 10]),
            32'(want), 1'b1);
  endtask

  task automatic lit_lane(input string name, input int k,
                          input logic [9:0] want);
    check($sformatf("%s lane%0d", name, k), 32'(bus.q[10*k +: 10]),
          32'(want), 1'b1);
  endtask

  logic [9:0] zseq [10];

  initial begin
    drive(24'h0, 6'h0, 1'b0);

    // Reset state, then tokens right after release.
    repeat (3) tick();
    lit_all("reset q", 10'h000);
    rst_n = 1'b1;
    tick();
    lit_all("post-reset token1", 10'h354);
    tick();
    lit_all("post-reset token2", 10'h354);

    // Continuous 0x00 from a control period.
    repeat (3) tick();
    zseq = '{10'h100, 10'h3FF, 10'h100, 10'h3FF, 10'h100,
             10'h3FF, 10'h100, 10'h3FF, 10'h100, 10'h100};
    drive(24'h000000, 6'h0, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      lit_lane($sformatf("zeros[%0d]", i), 0, zseq[i]);
    end

    // One control cycle, then 0xFF.
    drive(24'h000000, 6'h0, 1'b0);
    tick();
    drive(24'hFFFFFF, 6'h0, 1'b1);
    tick();
    lit_all("ctl before ff", 10'h354);
    tick();
    lit_all("ff[0]", 10'h200);
    tick();
    lit_all("ff[1]", 10'h0FF);

    // Control tokens, two cycles after input.
    drive(24'h0, 6'b010101, 1'b0);
    tick();
    drive(24'h0, 6'b101010, 1'b0);
    tick();
    drive(24'h0, 6'b111111, 1'b0);
    lit_all("token c01", 10'h0AB);
    tick();
    drive(24'h0, 6'b000000, 1'b0);
    lit_all("token c10", 10'h154);
    tick();
    lit_all("token c11", 10'h2AB);
    tick();
    lit_all("token c00", 10'h354);

    // Per-lane mixed tokens (lane0=01, lane1=10, lane2=11).
    drive(24'h0, 6'b111001, 1'b0);
    tick();
    drive(24'h0, 6'b000000, 1'b0);
    tick();
    lit_lane("mixtok", 0, 10'h0AB);
    lit_lane("mixtok", 1, 10'h154);
    lit_lane("mixtok", 2, 10'h2AB);

    // Three lanes 0x00 / 0xFF / 0x10, then a one-cycle control burst.
    drive(24'h10FF00, 6'h0, 1'b1);
    tick();
    tick();
    lit_lane("mix first", 0, 10'h100);
    lit_lane("mix first", 1, 10'h200);
    lit_lane("mix first", 2, 10'h1F0);
    repeat (5) tick();
    drive(24'h10FF00, 6'h0, 1'b0);
    tick();
    drive(24'h10FF00, 6'h0, 1'b1);
    tick();
    lit_all("burst token", 10'h354);
    tick();
    lit_lane("after burst", 0, 10'h100);
    lit_lane("after burst", 1, 10'h200);
    lit_lane("after burst", 2, 10'h1F0);

    // Mid-stream asynchronous reset.
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1 lit_all("async reset", 10'h000);
    tick();
    rst_n = 1'b1;
    tick();
    lit_all("after reset token", 10'h354);
    tick();
    lit_lane("after reset data", 0, 10'h100);

    // den toggling every cycle with varied pixels.
    for (int i = 0; i < 24; i++) begin
      drive(24'($urandom), 6'($urandom), i[0]);
      tick();
    end

    // Random traffic, mostly data with occasional control runs.
    for (int i = 0; i < 3000; i++) begin
      drive(24'($urandom), 6'($urandom), ($urandom_range(0, 7) != 0));
      tick();
    end

    drive(24'h0, 6'h0, 1'b0);
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
